alu_operand_shifter: RTL and testbench

Iterative operand-2 shifter placed directly upstream of the ALU adder's OP1 input. It takes a 32-bit register value and applies LSL, LSR, ASR, ROR or RRX, one bit position per clock tick. It produces the shifted operand and a shifter carry-out for the datapath to forward as OP1 and the logical-op C flag. A start/busy/done handshake lets the control unit stall while the shift runs.

---
 rtl/alu_shift_pkg.sv | 23 ++
 rtl/alu_shift_step.sv | 17 +
 rtl/alu_operand_shifter.sv | 69 ++++++
 tb/tb_alu_operand_shifter.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/alu_shift_pkg.sv
// alu_shift_pkg: shift encodings, FSM states and step-count helper for the operand shifter
package alu_shift_pkg;
  localparam int DATA_W = 32;
  localparam int AMT_W = 8;
  localparam int CNT_W = 6;
  typedef enum logic [2:0] {SH_LSL, SH_LSR, SH_ASR, SH_ROR, SH_RRX} shift_t;
  typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;
  function automatic shift_t eff_type(logic [1:0] typ, logic [AMT_W-1:0] amt, logic imm);
    return (imm && amt[4:0] == 5'd0 && typ == 2'b11) ? SH_RRX : shift_t'({1'b0, typ});
  endfunction
  // Immediate zero selects LSL#0 / LSR#32 / ASR#32 / RRX; other cases cap N so edge results fall out naturally
  function automatic logic [CNT_W-1:0] step_count(logic [1:0] typ, logic [AMT_W-1:0] amt, logic imm);
    logic [AMT_W-1:0] a;
    logic [CNT_W-1:0] cap;
    logic [4:0] ror_m1;
    a = imm ? {3'b000, amt[4:0]} : amt;
    cap = (typ == 2'b10) ? 6'd32 : 6'd33;
    ror_m1 = a[4:0] - 5'd1;
    if (imm && a == '0) return (typ == 2'b00) ? 6'd0 : (typ == 2'b11) ? 6'd1 : 6'd32;
    if (a == '0) return 6'd0;
    return (typ == 2'b11) ? {1'b0, ror_m1} + 6'd1 : (a > {2'b00, cap}) ? cap : a[CNT_W-1:0];
  endfunction
endpackage

// File: rtl/alu_shift_step.sv
// alu_shift_step: one-bit combinational shift step for LSL/LSR/ASR/ROR/RRX
module alu_shift_step
  import alu_shift_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  shift_t             typ,
  input  logic [WIDTH-1:0]   v,
  input  logic               c,
  output logic [WIDTH-1:0]   v_nx,
  output logic               c_nx
);
  logic msb;
  assign msb = (typ == SH_ASR) ? v[WIDTH-1] : (typ == SH_ROR) ? v[0] : (typ == SH_RRX) ? c : 1'b0;
  assign c_nx = (typ == SH_LSL) ? v[WIDTH-1] : v[0];
  assign v_nx = (typ == SH_LSL) ? {v[WIDTH-2:0], 1'b0} : {msb, v[WIDTH-1:1]};
endmodule

// File: rtl/alu_operand_shifter.sv
// alu_operand_shifter: iterative operand-2 shifter, one bit per enabled tick, start/busy/done handshake
module alu_operand_shifter
  import alu_shift_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int AMT_BITS = AMT_W
) (
  input  logic [4:0]          LOGISIM_CLOCK_TREE_0,
  input  logic                nRESET,
  input  logic                START,
  input  logic [1:0]          SHIFT_TYPE,
  input  logic [AMT_BITS-1:0] AMOUNT,
  input  logic                IMM_FORM,
  input  logic [WIDTH-1:0]    DATA_IN,
  input  logic                CFLAG_IN,
  output logic                BUSY,
  output logic                DONE,
  output logic [WIDTH-1:0]    RESULT,
  output logic                CARRY_OUT
);
  logic clk, tick, unused_tree;
  state_t state, state_nx;
  shift_t typ;
  logic [CNT_W-1:0] cnt, n_start;
  logic [WIDTH-1:0] val, step_v;
  logic carry, step_c, accept;
  assign clk = LOGISIM_CLOCK_TREE_0[4];
  assign tick = LOGISIM_CLOCK_TREE_0[2];
  assign unused_tree = ^{LOGISIM_CLOCK_TREE_0[3], LOGISIM_CLOCK_TREE_0[1:0]};
  assign n_start = step_count(SHIFT_TYPE, AMOUNT, IMM_FORM);
  assign accept = state == IDLE && START;
  alu_shift_step #(.WIDTH(WIDTH)) u_step (
    .typ  (typ),
    .v    (val),
    .c    (carry),
    .v_nx (step_v),
    .c_nx (step_c)
  );
  always_comb begin
    state_nx = (state == IDLE) ? (START ? ((n_start != '0) ? SHIFT : FIN) : IDLE) :
               (state == SHIFT) ? ((cnt == 6'd1) ? FIN : SHIFT) : IDLE;
  end
  // The working register doubles as RESULT, so a zero-step request leaves DATA_IN/CFLAG_IN as the answer
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      state <= IDLE;
      typ <= SH_LSL;
      cnt <= '0;
      val <= '0;
      carry <= 1'b0;
    end else if (tick) begin
      state <= state_nx;
      if (accept) begin
        typ <= eff_type(SHIFT_TYPE, AMOUNT, IMM_FORM);
        cnt <= n_start;
        val <= DATA_IN;
        carry <= CFLAG_IN;
      end else if (state == SHIFT) begin
        cnt <= cnt - 6'd1;
        val <= step_v;
        carry <= step_c;
      end
    end
  end
  assign BUSY = state == SHIFT;
  assign DONE = state == FIN;
  assign RESULT = val;
  assign CARRY_OUT = carry;
endmodule

// File: tb/tb_alu_operand_shifter.sv
// tb_alu_operand_shifter: directed vectors with a scoreboard queue checked by a DONE monitor
module tb_alu_operand_shifter;
  typedef struct {
    logic [31:0] r;
    logic        c;
    int          lat;
    longint      s;
  } exp_t;
  logic clk = 1'b0;
  logic tick = 1'b1;
  logic [4:0] tree;
  logic nrst, start, imm, cf, busy, done, cout;
  logic [1:0] styp;
  logic [7:0] amt;
  logic [31:0] din, res;
  longint cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  logic done_q = 1'b0;
  exp_t q[$];
  assign tree = {clk, 1'b0, tick, 2'b00};
  alu_operand_shifter dut (
    .LOGISIM_CLOCK_TREE_0 (tree),
    .nRESET               (nrst),
    .START                (start),
    .SHIFT_TYPE           (styp),
    .AMOUNT               (amt),
    .IMM_FORM             (imm),
    .DATA_IN              (din),
    .CFLAG_IN             (cf),
    .BUSY                 (busy),
    .DONE                 (done),
    .RESULT               (res),
    .CARRY_OUT            (cout)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (done && !done_q) begin
      chk("done_expected", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        exp_t e;
        e = q.pop_front();
        chk("result", res, e.r);
        chk("carry", {31'd0, cout}, {31'd0, e.c});
        chk("latency", 32'(cyc - e.s), 32'(e.lat));
      end
    end
    done_q <= done;
  end
  task automatic issue(logic [1:0] t, logic [7:0] a, logic im, logic [31:0] d, logic c,
                       logic [31:0] er, logic ec, int lat, bit push);
    int k;
    k = 0;
    @(negedge clk);
    while ((busy || done) && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("idle_wait", {30'd0, busy, done}, 32'd0);
    start = 1'b1;
    styp = t;
    amt = a;
    imm = im;
    din = d;
    cf = c;
    if (push) q.push_back('{er, ec, lat, cyc});
    @(negedge clk);
    start = 1'b0;
    din = ~d;
    cf = ~c;
    styp = ~t;
  endtask
  initial begin
    nrst = 1'b1;
    start = 1'b0;
    styp = 2'b00;
    amt = 8'd0;
    imm = 1'b0;
    din = 32'd0;
    cf = 1'b0;
    #2 nrst = 1'b0;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", res, 32'd0);
    chk("rst_carry", {31'd0, cout}, 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    issue(2'b00, 8'd4,   1'b0, 32'h8000_000F, 1'b0, 32'h0000_00F0, 1'b0, 5, 1);
    issue(2'b01, 8'd0,   1'b1, 32'h8000_0001, 1'b0, 32'h0000_0000, 1'b1, 33, 1);
    issue(2'b10, 8'd200, 1'b0, 32'h8000_0000, 1'b0, 32'hFFFF_FFFF, 1'b1, 33, 1);
    issue(2'b11, 8'd0,   1'b1, 32'h0000_0003, 1'b1, 32'h8000_0001, 1'b1, 2, 1);
    issue(2'b11, 8'd64,  1'b0, 32'h1234_5678, 1'b0, 32'h1234_5678, 1'b0, 33, 1);
    issue(2'b00, 8'd0,   1'b0, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 1'b1, 1, 1);
    issue(2'b00, 8'd0,   1'b1, 32'h0000_0055, 1'b0, 32'h0000_0055, 1'b0, 1, 1);
    issue(2'b01, 8'd33,  1'b0, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1'b0, 34, 1);
    issue(2'b00, 8'd32,  1'b0, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 33, 1);
    issue(2'b11, 8'd4,   1'b0, 32'h1234_567F, 1'b0, 32'hF123_4567, 1'b1, 5, 1);
    issue(2'b10, 8'd0,   1'b1, 32'h7FFF_FFFF, 1'b1, 32'h0000_0000, 1'b0, 33, 1);
    issue(2'b10, 8'd1,   1'b0, 32'h8000_0003, 1'b0, 32'hC000_0001, 1'b1, 2, 1);
    issue(2'b01, 8'hE4,  1'b1, 32'hABCD_1234, 1'b0, 32'h0ABC_D123, 1'b0, 5, 1);
    issue(2'b00, 8'd10,  1'b0, 32'h0000_0001, 1'b0, 32'h0000_0400, 1'b0, 14, 1);
    repeat (2) @(negedge clk);
    tick = 1'b0;
    repeat (3) @(negedge clk);
    tick = 1'b1;
    issue(2'b01, 8'd6,   1'b0, 32'hFFFF_0000, 1'b0, 32'h03FF_FC00, 1'b0, 7, 1);
    @(negedge clk);
    start = 1'b1;
    styp = 2'b00;
    amt = 8'd1;
    din = 32'h0000_0000;
    @(negedge clk);
    start = 1'b0;
    issue(2'b00, 8'd10,  1'b0, 32'hFFFF_FFFF, 1'b1, 32'd0, 1'b0, 0, 0);
    repeat (3) @(negedge clk);
    nrst = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_result", res, 32'd0);
    chk("abort_carry", {31'd0, cout}, 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    repeat (15) @(negedge clk);
    chk("post_abort_busy", {31'd0, busy}, 32'd0);
    chk("post_abort_done", {31'd0, done}, 32'd0);
    for (int k = 0; k < 200 && q.size() != 0; k++) @(negedge clk);
    chk("drain", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
